// File: rtl/wb_pkg.sv
// Write-back arbiter shared types: entry bundle and width helpers.
// Optional forwarding is enabled with the WB_FWD_EN macro.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

  // pointer carries one extra wrap bit
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // occupancy must represent 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU/LSU results, hazard lookup, RF write port.
// WB_FWD_EN adds the rs1/rs2 forwarding outputs.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic              alu_we;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_wd;
  logic              lsu_valid;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_wd;
  logic              lsu_ready;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_busy;
  logic              stall_req;
  logic              WE3;
  logic [REG_AW-1:0] A3;
  logic [XLEN-1:0]   WD3;
  logic [cnt_w(DEPTH)-1:0] q_count;
`ifdef WB_FWD_EN
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  logic              rs1_fwd_v;
  logic              rs2_fwd_v;
`endif

`ifdef WB_FWD_EN
  modport slave (
    input  alu_we, alu_rd, alu_wd,
    input  lsu_valid, lsu_rd, lsu_wd,
    input  rs1_q, rs2_q, rd_q,
    output lsu_ready, rs1_busy, rs2_busy, rd_busy,
    output stall_req, WE3, A3, WD3, q_count,
    output rs1_fwd, rs2_fwd, rs1_fwd_v, rs2_fwd_v
  );
  modport master (
    output alu_we, alu_rd, alu_wd,
    output lsu_valid, lsu_rd, lsu_wd,
    output rs1_q, rs2_q, rd_q,
    input  lsu_ready, rs1_busy, rs2_busy, rd_busy,
    input  stall_req, WE3, A3, WD3, q_count,
    input  rs1_fwd, rs2_fwd, rs1_fwd_v, rs2_fwd_v
  );
`else
  modport slave (
    input  alu_we, alu_rd, alu_wd,
    input  lsu_valid, lsu_rd, lsu_wd,
    input  rs1_q, rs2_q, rd_q,
    output lsu_ready, rs1_busy, rs2_busy, rd_busy,
    output stall_req, WE3, A3, WD3, q_count
  );
  modport master (
    output alu_we, alu_rd, alu_wd,
    output lsu_valid, lsu_rd, lsu_wd,
    output rs1_q, rs2_q, rd_q,
    input  lsu_ready, rs1_busy, rs2_busy, rd_busy,
    input  stall_req, WE3, A3, WD3, q_count
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Long-latency result queue; exposes entries oldest-first for the CAM.
// Pointers carry a wrap bit so full/empty need no separate flag.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output logic      full_o,
  output logic      empty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output wb_entry_t ent_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  wb_entry_t     mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_o = (wp_q == rp_q);
  assign count_o = CW'(wp_q - rp_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // slot k is the k-th oldest queued entry
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ent_o[k] = mem_q[AW'(rp_q[AW-1:0] + AW'(k))];
    assign vld_o[k] = (CW'(k) < count_o);
  end

  // pointer advance
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + PW'(1);
    if (do_pop)  rp_d = rp_q + PW'(1);
  end

  // pointer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// RF write-port arbiter: ALU first, queued LSU/MUL results otherwise.
// WB_FWD_EN adds youngest-match forwarding of queued data.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  wb_entry_t       ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] live;
  logic            alu_gnt;
  logic            push;
  logic            pop;
  wb_entry_t       din;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            rs1_m, rs2_m, rd_m;
  logic [XLEN-1:0] rs1_dat, rs2_dat;

  assign alu_gnt = rst & bus.alu_we & (bus.alu_rd != '0);
  assign pop     = rst & ~alu_gnt & ~empty;
  assign bus.lsu_ready = rst & ~full;
  assign push    = bus.lsu_valid & bus.lsu_ready &
                   (bus.lsu_rd != '0);
  assign din     = '{rd: bus.lsu_rd, wd: bus.lsu_wd};
  assign bus.q_count   = count;
  assign bus.stall_req = stall_q;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .ent_o   (ent),
    .vld_o   (vld)
  );

  // write-port grant: ALU wins, else drain the head
  always_comb begin
    bus.WE3 = 1'b0;
    bus.A3  = '0;
    bus.WD3 = '0;
    if (alu_gnt) begin
      bus.WE3 = 1'b1;
      bus.A3  = bus.alu_rd;
      bus.WD3 = bus.alu_wd;
    end else if (pop) begin
      bus.WE3 = 1'b1;
      bus.A3  = ent[0].rd;
      bus.WD3 = ent[0].wd;
    end
  end

  // hazard CAM; the head leaving this cycle no longer counts
  always_comb begin
    live    = vld;
    live[0] = vld[0] & ~pop;
    rs1_m   = 1'b0;
    rs2_m   = 1'b0;
    rd_m    = 1'b0;
    rs1_dat = '0;
    rs2_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (live[k]) begin
        if (ent[k].rd == bus.rs1_q) begin
          rs1_m   = 1'b1;
          rs1_dat = ent[k].wd;
        end
        if (ent[k].rd == bus.rs2_q) begin
          rs2_m   = 1'b1;
          rs2_dat = ent[k].wd;
        end
        if (ent[k].rd == bus.rd_q) rd_m = 1'b1;
      end
    end
  end

  assign bus.rs1_busy = rst & rs1_m & (bus.rs1_q != '0);
  assign bus.rs2_busy = rst & rs2_m & (bus.rs2_q != '0);
  assign bus.rd_busy  = rst & rd_m & (bus.rd_q != '0);

`ifdef WB_FWD_EN
  assign bus.rs1_fwd_v = bus.rs1_busy;
  assign bus.rs2_fwd_v = bus.rs2_busy;
  assign bus.rs1_fwd   = bus.rs1_busy ? rs1_dat : '0;
  assign bus.rs2_fwd   = bus.rs2_busy ? rs2_dat : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_dat, rs2_dat};
`endif

  // starvation count: ALU kept the port while entries waited
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (alu_gnt) begin
      if (starve_q == SW'(STARVE_MAX - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // starvation state and one-cycle forced-drain request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, STARVE_MAX=3).
// Define WB_FWD_EN to also exercise the forwarding outputs.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errs;

  wb_arbiter_if #(.DEPTH(4)) bus ();

  wb_arbiter #(
    .DEPTH      (4),
    .STARVE_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alu_we    = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wd    = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_wd    = '0;
    bus.rs1_q     = '0;
    bus.rs2_q     = '0;
    bus.rd_q      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd3; bus.alu_wd = 32'h33;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6;
    step(); #1;
    checks++; if (bus.WE3 !== 1'b0) begin errs++; $display("FAIL rst_we3: got %0b exp 0", bus.WE3); end
    checks++; if (bus.A3 !== 5'd0) begin errs++; $display("FAIL rst_a3: got %0d exp 0", bus.A3); end
    checks++; if (bus.WD3 !== 32'h0) begin errs++; $display("FAIL rst_wd3: got %h exp 0", bus.WD3); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %0b exp 0", bus.lsu_ready); end
    checks++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL rst_stall: got %0b exp 0", bus.stall_req); end
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL rst_count: got %0d exp 0", bus.q_count); end
    idle();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_lsu_only();
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd5; bus.lsu_wd = 32'hDEADBEEF;
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin errs++; $display("FAIL lsu_ready: got %0b exp 1", bus.lsu_ready); end
    checks++; if (bus.WE3 !== 1'b0) begin errs++; $display("FAIL lsu_nopass: got %0b exp 0", bus.WE3); end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.q_count !== 3'd1) begin errs++; $display("FAIL lsu_count1: got %0d exp 1", bus.q_count); end
    checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd5 || bus.WD3 !== 32'hDEADBEEF) begin
      errs++; $display("FAIL lsu_write: got we=%0b a=%0d d=%h exp 1/5/deadbeef", bus.WE3, bus.A3, bus.WD3); end
    step(); #1;
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL lsu_count0: got %0d exp 0", bus.q_count); end
    checks++; if (bus.WE3 !== 1'b0) begin errs++; $display("FAIL lsu_idle: got %0b exp 0", bus.WE3); end
  endtask

  task automatic test_fill();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'h11;
    for (int i = 0; i < 4; i++) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_rd = 5'(10 + i);
      bus.lsu_wd = 32'(32'h100 + 10 + i);
      #1;
      checks++; if (bus.lsu_ready !== 1'b1) begin errs++; $display("FAIL fill_ready%0d: got %0b exp 1", i, bus.lsu_ready); end
      checks++; if (bus.A3 !== 5'd1 || bus.WE3 !== 1'b1) begin errs++; $display("FAIL fill_alu%0d: got a=%0d exp 1", i, bus.A3); end
      checks++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL fill_stall%0d: got %0b exp 0", i, bus.stall_req); end
      step();
    end
    bus.lsu_rd = 5'd14; bus.lsu_wd = 32'h10E;
    bus.alu_we = 1'b0;
    #1;
    checks++; if (bus.q_count !== 3'd4) begin errs++; $display("FAIL fill_full: got %0d exp 4", bus.q_count); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errs++; $display("FAIL fill_noready: got %0b exp 0", bus.lsu_ready); end
    checks++; if (bus.stall_req !== 1'b1) begin errs++; $display("FAIL fill_stall1: got %0b exp 1", bus.stall_req); end
    checks++; if (bus.A3 !== 5'd10 || bus.WD3 !== 32'h10A) begin
      errs++; $display("FAIL fill_drain1: got a=%0d d=%h exp 10/10a", bus.A3, bus.WD3); end
    step();
    bus.lsu_valid = 1'b0;
    bus.alu_we = 1'b1;
    #1;
    checks++; if (bus.q_count !== 3'd3) begin errs++; $display("FAIL fill_blocked: got %0d exp 3", bus.q_count); end
    checks++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL fill_pulse: got %0b exp 0", bus.stall_req); end
    step(); #1;
    checks++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL fill_c6: got %0b exp 0", bus.stall_req); end
    step(); #1;
    checks++; if (bus.stall_req !== 1'b0) begin errs++; $display("FAIL fill_c7: got %0b exp 0", bus.stall_req); end
    step();
    bus.alu_we = 1'b0;
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin errs++; $display("FAIL fill_stall2: got %0b exp 1", bus.stall_req); end
    checks++; if (bus.A3 !== 5'd11 || bus.WD3 !== 32'h10B) begin
      errs++; $display("FAIL fill_drain2: got a=%0d d=%h exp 11/10b", bus.A3, bus.WD3); end
    step(); #1;
    checks++; if (bus.stall_req !== 1'b0 || bus.q_count !== 3'd2) begin
      errs++; $display("FAIL fill_c9: got stall=%0b cnt=%0d exp 0/2", bus.stall_req, bus.q_count); end
    checks++; if (bus.A3 !== 5'd12) begin errs++; $display("FAIL fill_drain3: got %0d exp 12", bus.A3); end
    step(); #1;
    checks++; if (bus.A3 !== 5'd13) begin errs++; $display("FAIL fill_drain4: got %0d exp 13", bus.A3); end
    step(); #1;
    checks++; if (bus.q_count !== 3'd0 || bus.WE3 !== 1'b0) begin
      errs++; $display("FAIL fill_empty: got cnt=%0d we=%0b exp 0/0", bus.q_count, bus.WE3); end
  endtask

  task automatic test_x0();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd0; bus.alu_wd = 32'hBAD;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_wd = 32'h77;
    #1;
    checks++; if (bus.WE3 !== 1'b0) begin errs++; $display("FAIL x0_alu: got %0b exp 0", bus.WE3); end
    step();
    bus.lsu_rd = 5'd0; bus.lsu_wd = 32'h55;
    #1;
    checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'h77) begin
      errs++; $display("FAIL x0_head: got we=%0b a=%0d d=%h exp 1/7/77", bus.WE3, bus.A3, bus.WD3); end
    checks++; if (bus.lsu_ready !== 1'b1) begin errs++; $display("FAIL x0_ready: got %0b exp 1", bus.lsu_ready); end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL x0_count: got %0d exp 0", bus.q_count); end
    idle();
    step();
  endtask

  task automatic test_hazard();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd2; bus.alu_wd = 32'h22;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_wd = 32'h99;
    bus.rs1_q = 5'd9; bus.rs2_q = 5'd0; bus.rd_q = 5'd9;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errs++; $display("FAIL haz_early: got %0b exp 0", bus.rs1_busy); end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin errs++; $display("FAIL haz_rs1: got %0b exp 1", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0) begin errs++; $display("FAIL haz_rs2x0: got %0b exp 0", bus.rs2_busy); end
    checks++; if (bus.rd_busy !== 1'b1) begin errs++; $display("FAIL haz_rd: got %0b exp 1", bus.rd_busy); end
    step();
    bus.alu_we = 1'b0;
    #1;
    checks++; if (bus.A3 !== 5'd9 || bus.WD3 !== 32'h99) begin
      errs++; $display("FAIL haz_pop: got a=%0d d=%h exp 9/99", bus.A3, bus.WD3); end
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rd_busy !== 1'b0) begin
      errs++; $display("FAIL haz_excl: got rs1=%0b rd=%0b exp 0/0", bus.rs1_busy, bus.rd_busy); end
    step(); #1;
    checks++; if (bus.q_count !== 3'd0 || bus.rs1_busy !== 1'b0) begin
      errs++; $display("FAIL haz_after: got cnt=%0d rs1=%0b exp 0/0", bus.q_count, bus.rs1_busy); end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd3; bus.alu_wd = 32'h33;
    for (int i = 0; i < 3; i++) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_rd = 5'(20 + i);
      bus.lsu_wd = 32'(i);
      step();
    end
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.q_count !== 3'd3) begin errs++; $display("FAIL mid_count3: got %0d exp 3", bus.q_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.WE3 !== 1'b0) begin errs++; $display("FAIL mid_we3: got %0b exp 0", bus.WE3); end
    checks++; if (bus.q_count !== 3'd0) begin errs++; $display("FAIL mid_count0: got %0d exp 0", bus.q_count); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errs++; $display("FAIL mid_ready: got %0b exp 0", bus.lsu_ready); end
    step();
    rst = 1'b1;
    bus.alu_we = 1'b0;
    bus.rs1_q = 5'd20;
    #1;
    checks++; if (bus.q_count !== 3'd0 || bus.WE3 !== 1'b0) begin
      errs++; $display("FAIL mid_empty: got cnt=%0d we=%0b exp 0/0", bus.q_count, bus.WE3); end
    checks++; if (bus.rs1_busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errs++; $display("FAIL mid_clear: got busy=%0b stall=%0b exp 0/0", bus.rs1_busy, bus.stall_req); end
    step();
    idle();
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'h11;
    bus.rs1_q = 5'd4;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_wd = 32'd1;
    step();
    bus.lsu_wd = 32'd2;
    #1;
    checks++; if (bus.rs1_fwd !== 32'd1 || bus.rs1_fwd_v !== 1'b1) begin
      errs++; $display("FAIL fwd_one: got d=%0d v=%0b exp 1/1", bus.rs1_fwd, bus.rs1_fwd_v); end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.rs1_fwd !== 32'd2 || bus.rs1_fwd_v !== 1'b1 || bus.rs1_busy !== 1'b1) begin
      errs++; $display("FAIL fwd_young: got d=%0d v=%0b exp 2/1", bus.rs1_fwd, bus.rs1_fwd_v); end
    step();
    bus.alu_we = 1'b0;
    #1;
    checks++; if (bus.A3 !== 5'd4 || bus.WD3 !== 32'd1 || bus.rs1_fwd !== 32'd2) begin
      errs++; $display("FAIL fwd_pop1: got a=%0d d=%0d f=%0d exp 4/1/2", bus.A3, bus.WD3, bus.rs1_fwd); end
    step(); #1;
    checks++; if (bus.WD3 !== 32'd2 || bus.rs1_fwd_v !== 1'b0) begin
      errs++; $display("FAIL fwd_pop2: got d=%0d v=%0b exp 2/0", bus.WD3, bus.rs1_fwd_v); end
    step();
    idle();
  endtask
`endif

  initial begin
    checks = 0;
    errs   = 0;
    idle();
    test_reset();
    test_lsu_only();
    test_fill();
    test_x0();
    test_hazard();
    test_reset_midstream();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
